// File: rtl/fir_pkg.sv
// Shared types and constants for the serial-MAC FIR filter: FSM state encoding,
// default geometry and the default tap coefficient table.
package fir_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_LENGHT = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOADING_STATE,
        CALCULATION_STATE,
        OUTPUT_STATE
    } state_t;

    typedef logic [DEFAULT_LENGHT*DEFAULT_WIDTH-1:0] coeff_vec_t;

    // Tap k lives in bits [k*WIDTH +: WIDTH]; the ends hold the signed extremes.
    function automatic coeff_vec_t gen_coeffs();
        coeff_vec_t v;
        int         c;
        v = '0;
        for (int k = 0; k < DEFAULT_LENGHT; k++) begin
            if (k == 0)
                c = 32767;
            else if (k == DEFAULT_LENGHT - 1)
                c = -32768;
            else
                c = k * 513 - 16000;
            v[k*DEFAULT_WIDTH +: DEFAULT_WIDTH] = c[DEFAULT_WIDTH-1:0];
        end
        return v;
    endfunction

    localparam coeff_vec_t COEFFS = gen_coeffs();

endpackage

// File: rtl/fir_filter_if.sv
// Sample-in / result-out handshake bundle of the FIR filter.
interface fir_filter_if
    import fir_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int OUT_WIDTH = 2*DEFAULT_WIDTH + $clog2(DEFAULT_LENGHT)
);
    logic signed [WIDTH-1:0]     FIR_input;
    logic                        input_valid;
    logic signed [OUT_WIDTH-1:0] FIR_output;
    logic                        output_valid;
    logic                        ready_for_input;

    modport master (
        output FIR_input, input_valid,
        input  FIR_output, output_valid, ready_for_input
    );

    modport slave (
        input  FIR_input, input_valid,
        output FIR_output, output_valid, ready_for_input
    );
endinterface

// File: rtl/fir_control.sv
// Sequencer for the serial FIR: accept, shift, LENGHT MAC cycles, publish.
//
// state             | meaning
// IDLE              | ready for a sample; clears acc on the cycle after OUTPUT
// LOADING_STATE     | shift captured sample into the delay line
// CALCULATION_STATE | one MAC per cycle, tap_cnt = 0 .. LENGHT-1
// OUTPUT_STATE      | register acc into FIR_output and pulse output_valid
module fir_control
    import fir_pkg::*;
#(
    parameter int LENGHT = DEFAULT_LENGHT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       input_valid,
    output logic                       load_input,
    output logic                       load_result,
    output logic                       counter_co,
    output logic                       clr_result,
    output logic                       output_valid_interconnect,
    output logic                       ready_for_input,
    output logic [$clog2(LENGHT)-1:0]  tap_cnt,
    output state_t                     present_state
);
    localparam int            CW       = $clog2(LENGHT);
    localparam logic [CW-1:0] LAST_TAP = CW'(LENGHT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          from_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            from_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_out_q <= (state_q == OUTPUT_STATE);
        end
    end

    always_comb begin
        state_d                   = state_q;
        cnt_d                     = cnt_q;
        load_input                = 1'b0;
        load_result               = 1'b0;
        counter_co                = 1'b0;
        clr_result                = 1'b0;
        output_valid_interconnect = 1'b0;
        ready_for_input           = 1'b0;
        case (state_q)
            IDLE: begin
                ready_for_input = 1'b1;
                clr_result      = from_out_q;
                if (input_valid)
                    state_d = LOADING_STATE;
            end
            LOADING_STATE: begin
                load_input = 1'b1;
                state_d    = CALCULATION_STATE;
            end
            CALCULATION_STATE: begin
                load_result = 1'b1;
                if (cnt_q == LAST_TAP) begin
                    counter_co = 1'b1;
                    cnt_d      = '0;
                    state_d    = OUTPUT_STATE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUTPUT_STATE: begin
                output_valid_interconnect = 1'b1;
                state_d                   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tap_cnt       = cnt_q;
    assign present_state = state_q;

endmodule

// File: rtl/fir_filter.sv
// Direct-form FIR with one shared multiplier: delay line, full-precision MAC
// accumulator and held output register, sequenced by fir_control.
module fir_filter
    import fir_pkg::*;
#(
    parameter int                       WIDTH       = DEFAULT_WIDTH,
    parameter int                       LENGHT      = DEFAULT_LENGHT,
    parameter logic [LENGHT*WIDTH-1:0]  COEFF_TABLE = COEFFS
) (
    input  logic       clk,
    input  logic       reset,
    fir_filter_if.slave bus
);
    localparam int OUT_WIDTH = 2*WIDTH + $clog2(LENGHT);
    localparam int CW        = $clog2(LENGHT);

    logic                        load_input, load_result, counter_co, clr_result;
    logic                        output_valid_interconnect, ready_for_input;
    logic [CW-1:0]               tap_cnt;
    state_t                      present_state;

    logic signed [WIDTH-1:0]     coef [LENGHT];
    logic signed [WIDTH-1:0]     tap_q [LENGHT];
    logic signed [WIDTH-1:0]     sample_q;
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0] out_q;
    logic                        ov_q;

    fir_control #(.LENGHT(LENGHT)) control (
        .clk                       (clk),
        .reset                     (reset),
        .input_valid               (bus.input_valid),
        .load_input                (load_input),
        .load_result               (load_result),
        .counter_co                (counter_co),
        .clr_result                (clr_result),
        .output_valid_interconnect (output_valid_interconnect),
        .ready_for_input           (ready_for_input),
        .tap_cnt                   (tap_cnt),
        .present_state             (present_state)
    );

    for (genvar g = 0; g < LENGHT; g++) begin : g_coef
        assign coef[g] = COEFF_TABLE[g*WIDTH +: WIDTH];
    end

    // Accumulator is wide enough for LENGHT worst-case products, so no saturation.
    always_comb begin
        prod  = tap_q[tap_cnt] * coef[tap_cnt];
        acc_d = acc_q;
        if (clr_result)
            acc_d = '0;
        else if (load_result)
            acc_d = acc_q + OUT_WIDTH'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            for (int k = 0; k < LENGHT; k++)
                tap_q[k] <= '0;
            acc_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            if (present_state == IDLE && bus.input_valid)
                sample_q <= bus.FIR_input;
            if (load_input) begin
                tap_q[0] <= sample_q;
                for (int k = 1; k < LENGHT; k++)
                    tap_q[k] <= tap_q[k-1];
            end
            acc_q <= acc_d;
            ov_q  <= output_valid_interconnect;
            if (output_valid_interconnect)
                out_q <= acc_q;
        end
    end

    assert property (@(posedge clk) disable iff (reset) counter_co |=> output_valid_interconnect);

    assign bus.FIR_output      = out_q;
    assign bus.output_valid    = ov_q;
    assign bus.ready_for_input = ready_for_input;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: impulse/vector table, worst-case step,
// handshake framing, strobe sequencing and mid-calculation reset.
module tb_fir_filter;
    import fir_pkg::*;

    localparam int W  = 16;
    localparam int L  = 64;
    localparam int OW = 38;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic signed [W-1:0]   in_data = '0;
    logic                  in_valid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int     coef_tb [L];
    longint hist [L];

    typedef struct {
        logic signed [W-1:0] x;
        longint              y;
    } vec_t;
    vec_t vecs [70];

    fir_filter_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus ();
    fir_filter_if #(.WIDTH(W), .OUT_WIDTH(OW)) bus_wc ();

    assign bus.FIR_input      = in_data;
    assign bus.input_valid    = in_valid;
    assign bus_wc.FIR_input   = in_data;
    assign bus_wc.input_valid = in_valid;

    fir_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fir_filter #(.COEFF_TABLE({64{16'h8000}})) dut_wc (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_wc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < L; k++) hist[k] = 0;
    endfunction

    function automatic longint model_push(input longint x);
        longint y;
        for (int k = L-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        y = 0;
        for (int k = 0; k < L; k++) y += longint'(coef_tb[k]) * hist[k];
        return y;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Offer one sample, then wait for its result; latency counted from the accepting edge.
    task automatic send(input logic signed [W-1:0] x, output longint y, output longint y_wc);
        int waitc;
        int lat;
        waitc = 0;
        while (!bus.ready_for_input && waitc < 200) begin
            tick();
            waitc++;
        end
        if (!bus.ready_for_input) chk("ready_wait", 0, 1);
        in_data  = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!bus.output_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", lat, 66);
        y    = bus.FIR_output;
        y_wc = bus_wc.FIR_output;
        tick();
        chk("valid_pulse_width", bus.output_valid, 0);
    endtask

    initial begin
        longint y, y_wc, exp_y;
        int     cnt_v, cnt_lr, nz;
        logic signed [W-1:0] xs [6];

        for (int k = 0; k < L; k++) begin
            if (k == 0)          coef_tb[k] = 32767;
            else if (k == L - 1) coef_tb[k] = -32768;
            else                 coef_tb[k] = k * 513 - 16000;
        end

        // Impulse entries expect the raw coefficients; the tail uses the model.
        xs = '{16'sd3, -16'sd2, 16'sd100, -16'sd32768, 16'sd32767, -16'sd1};
        model_clear();
        for (int k = 0; k < L; k++) begin
            vecs[k].x = (k == 0) ? 16'sd1 : 16'sd0;
            vecs[k].y = coef_tb[k];
            void'(model_push(longint'(vecs[k].x)));
        end
        for (int k = 0; k < 6; k++) begin
            vecs[L+k].x = xs[k];
            vecs[L+k].y = model_push(longint'(xs[k]));
        end

        // Reset and idle
        tick();
        do_reset();
        chk("rst_out", bus.FIR_output, 0);
        chk("rst_valid", bus.output_valid, 0);
        chk("rst_ready", bus.ready_for_input, 1);
        chk("rst_state", longint'(dut.control.present_state), longint'(IDLE));
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.output_valid) cnt_v++;
        end
        chk("idle_no_valid", cnt_v, 0);

        // Impulse and mixed vectors
        for (int i = 0; i < 70; i++) begin
            send(vecs[i].x, y, y_wc);
            chk($sformatf("vec%0d", i), y, vecs[i].y);
        end

        // Strobe sequencing over one frame
        do_reset();
        in_data  = 16'sd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_lr = 0;
        for (int c = 0; c <= 66; c++) begin
            chk($sformatf("load_input_c%0d", c), dut.control.load_input, (c == 0) ? 1 : 0);
            chk($sformatf("load_result_c%0d", c), dut.control.load_result, (c >= 1 && c <= 64) ? 1 : 0);
            chk($sformatf("counter_co_c%0d", c), dut.control.counter_co, (c == 64) ? 1 : 0);
            chk($sformatf("ovi_c%0d", c), dut.control.output_valid_interconnect, (c == 65) ? 1 : 0);
            chk($sformatf("ready_c%0d", c), bus.ready_for_input, (c == 66) ? 1 : 0);
            chk($sformatf("clr_c%0d", c), dut.control.clr_result, (c == 66) ? 1 : 0);
            if (dut.control.load_result) cnt_lr++;
            tick();
        end
        chk("load_result_count", cnt_lr, 64);

        // Handshake: input_valid held high, data changes every cycle
        do_reset();
        model_clear();
        in_valid = 1'b1;
        in_data  = W'(0 * 37 - 500);
        tick();
        for (int c = 0; c <= 200; c++) begin
            if (c % 67 == 0) exp_y = model_push(longint'(c * 37 - 500));
            chk($sformatf("hs_ready_c%0d", c), bus.ready_for_input, (c % 67 == 66) ? 1 : 0);
            chk($sformatf("hs_valid_c%0d", c), bus.output_valid, (c % 67 == 66) ? 1 : 0);
            if (c % 67 == 66) chk($sformatf("hs_out_c%0d", c), bus.FIR_output, exp_y);
            in_data = W'((c + 1) * 37 - 500);
            if (c < 200) tick();
        end
        in_valid = 1'b0;

        // Reset during the 10th MAC cycle aborts the frame
        tick();
        in_data  = 16'sd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        chk("abort_state", longint'(dut.control.present_state), longint'(IDLE));
        chk("abort_acc", dut.acc_q, 0);
        nz = 0;
        for (int k = 0; k < L; k++) if (dut.tap_q[k] != 0) nz++;
        chk("abort_taps_clear", nz, 0);
        cnt_v = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.output_valid) cnt_v++;
            tick();
        end
        chk("abort_no_valid", cnt_v, 0);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0, y, y_wc);
            chk($sformatf("post_abort_imp%0d", i), y, coef_tb[i]);
        end

        // Worst-case step on the all -32768 coefficient instance
        do_reset();
        for (int i = 0; i < L; i++) begin
            send(-16'sd32768, y, y_wc);
            if (i == 0) chk("step_first", y_wc, 64'sd1073741824);
        end
        chk("step_final", y_wc, 64'sd68719476736);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
